// File: rtl/servant_uart_tx.sv
// servant_uart_tx: Wishbone-slave 8N1 UART transmitter.
// The CPU pushes bytes into a small circular FIFO. An FSM shifts each byte out
// LSB-first on o_tx at DIV clock cycles per bit. Queued bytes are sent with no
// idle gap between frames.
//
// Ports:
//   i_clk     system clock
//   i_rst     synchronous, active-high reset
//   i_wb_cyc  bus cycle request (held by the master until ack)
//   i_wb_we   1 = push i_wb_dat into the FIFO, 0 = read the status word
//   i_wb_dat  byte to transmit
//   o_wb_rdt  registered status word:
//             bit0 busy, bit1 full, bit2 empty, bit3 overflow (sticky,
//             cleared by a read), bits[15:8] FIFO count
//   o_wb_ack  one-cycle acknowledge
//   o_tx      serial line, idle high, registered
module servant_uart_tx #(
  parameter int unsigned DIV   = 139,
  parameter int unsigned DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [7:0]  i_wb_dat,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_tx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [15:0] BIT_LAST = 16'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_n;
  logic [15:0] baud, baud_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic        tx_n;
  logic        pop;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic        strobe, wr_stb, rd_stb;
  logic        full, empty, push, bit_end;
  logic [7:0]  head;
  logic [31:0] status;

  assign strobe  = i_wb_cyc & ~o_wb_ack;
  assign wr_stb  = strobe & i_wb_we;
  assign rd_stb  = strobe & ~i_wb_we;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Fullness is judged on the pre-edge count, so a same-cycle pop does not
  // make room for a write that finds the FIFO full.
  assign push    = wr_stb & ~full;
  assign head    = mem[rd_ptr];
  assign bit_end = (baud == '0);
  assign status  = {16'h0000, 8'(count), 4'h0, overflow, empty, full,
                    (state != IDLE)};

  // Bus side: acknowledge, status register, overflow flag, FIFO bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
      overflow <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      o_wb_ack <= i_wb_cyc & ~o_wb_ack;
      if (rd_stb) begin
        o_wb_rdt <= status;
        overflow <= 1'b0;
      end else if (wr_stb) begin
        o_wb_rdt <= '0;
        if (full)
          overflow <= 1'b1;
      end
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr] <= i_wb_dat;
  end

  // Serializer state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      baud  <= '0;
      idx   <= '0;
      shift <= '0;
      o_tx  <= 1'b1;
    end else begin
      state <= state_n;
      baud  <= baud_n;
      idx   <= idx_n;
      shift <= shift_n;
      o_tx  <= tx_n;
    end
  end

  // Serializer next state. Every bit period starts by loading DIV-1 into the
  // baud counter; the bit ends on the cycle the counter reads zero.
  always_comb begin
    state_n = state;
    baud_n  = bit_end ? baud : baud - 1'b1;
    idx_n   = idx;
    shift_n = shift;
    tx_n    = o_tx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          tx_n    = 1'b0;
          baud_n  = BIT_LAST;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_n   = '0;
          tx_n    = shift[0];
          baud_n  = BIT_LAST;
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = BIT_LAST;
          if (idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n = shift >> 1;
            idx_n   = idx + 1'b1;
            tx_n    = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when a byte is waiting.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            tx_n    = 1'b0;
            baud_n  = BIT_LAST;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_servant_uart_tx.sv
// Testbench for servant_uart_tx (DIV=4, DEPTH=4). A queue-based reference
// model predicts o_tx, o_wb_ack and o_wb_rdt every cycle; directed tables and
// sequences add explicit constant expectations for the key scenarios.
module tb_servant_uart_tx;

  localparam int unsigned DIV   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        we  = 1'b0;
  logic [7:0]  dat = 8'h00;
  logic [31:0] rdt;
  logic        ack;
  logic        tx;

  servant_uart_tx #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_wb_cyc (cyc),
    .i_wb_we  (we),
    .i_wb_dat (dat),
    .o_wb_rdt (rdt),
    .o_wb_ack (ack),
    .o_tx     (tx)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;
  int wr_edge = 0;
  bit tx_log[$];

  // Reference model state
  logic [7:0]  m_fifo[$];
  bit          m_line[$];
  bit          m_ovf = 1'b0;
  bit          m_ack = 1'b0;
  logic [31:0] m_rdt = '0;

  typedef struct {
    bit          we;
    logic [7:0]  dat;
    logic [31:0] exp_rdt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Line level k cycles into an 8N1 frame carrying b.
  function automatic bit frame_lvl(input logic [7:0] b, input int k);
    int bi;
    bi = k / int'(DIV);
    if (bi == 0) return 1'b0;
    if (bi >= 9) return 1'b1;
    return b[bi-1];
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    logic        full_pre;
    logic [31:0] st;
    logic [7:0]  b;
    bit          stb;
    if (rst) begin
      m_fifo.delete();
      m_line.delete();
      m_ack = 1'b0;
      m_rdt = '0;
      m_ovf = 1'b0;
      return;
    end
    stb = cyc && !m_ack;
    full_pre = (m_fifo.size() == DEPTH);
    st = '0;
    st[0] = (m_line.size() != 0);
    st[1] = full_pre;
    st[2] = (m_fifo.size() == 0);
    st[3] = m_ovf;
    st[15:8] = 8'(m_fifo.size());
    if (m_line.size() != 0) void'(m_line.pop_front());
    if (m_line.size() == 0 && m_fifo.size() != 0) begin
      b = m_fifo.pop_front();
      for (int k = 0; k < FRAME; k++) m_line.push_back(frame_lvl(b, k));
    end
    if (stb && we) begin
      if (!full_pre) m_fifo.push_back(dat);
      else m_ovf = 1'b1;
      m_rdt = '0;
    end else if (stb) begin
      m_rdt = st;
      m_ovf = 1'b0;
    end
    m_ack = cyc && !m_ack;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc_n++;
    tx_log.push_back(tx);
    check("tx",  {31'b0, tx},  {31'b0, (m_line.size() != 0) ? m_line[0] : 1'b1});
    check("ack", {31'b0, ack}, {31'b0, m_ack});
    check("rdt", rdt, m_rdt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wb_write(input logic [7:0] b);
    cyc = 1'b1; we = 1'b1; dat = b;
    cycle();
    wr_edge = cyc_n;
    cycle();
    cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(output logic [31:0] r);
    cyc = 1'b1; we = 1'b0;
    cycle();
    cycle();
    r = rdt;
    cyc = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [7:0] b, input int start);
    for (int k = 0; k < FRAME; k++)
      check(name, {31'b0, tx_log[start+k]}, {31'b0, frame_lvl(b, k)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    vec_t tbl[8];
    int e, e1, rst_edge, zeros;
    tx_log.push_back(1'b1);  // tx_log[n] holds o_tx after edge n

    // 1: reset, then status read
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t1_tx_in_reset", {31'b0, tx}, 32'd1);
    end
    rst = 1'b0;
    cyc = 1'b1; we = 1'b0;
    cycle();
    check("t1_ack_hi", {31'b0, ack}, 32'd1);
    check("t1_status", rdt, 32'h0000_0004);
    cycle();
    check("t1_ack_lo", {31'b0, ack}, 32'd0);
    cyc = 1'b0;
    idle(2);
    check("t1_tx_idle", {31'b0, tx}, 32'd1);

    // 2: single frame 0x55
    wb_write(8'h55);
    e = wr_edge;
    idle(9);
    wb_read(r);
    check("t2_busy", r, 32'h0000_0005);
    idle(40);
    wb_read(r);
    check("t2_after", r, 32'h0000_0004);
    check("t2_pre_fall", {31'b0, tx_log[e]}, 32'd1);
    check_frame("t2_frame", 8'h55, e + 1);

    // 3: overflow with six back-to-back writes
    tbl[0] = '{1'b1, 8'h11, 32'h0};
    tbl[1] = '{1'b1, 8'h22, 32'h0};
    tbl[2] = '{1'b1, 8'h33, 32'h0};
    tbl[3] = '{1'b1, 8'h44, 32'h0};
    tbl[4] = '{1'b1, 8'h55, 32'h0};
    tbl[5] = '{1'b1, 8'h66, 32'h0};
    tbl[6] = '{1'b0, 8'h00, 32'h0000_040B};
    tbl[7] = '{1'b0, 8'h00, 32'h0000_0403};
    e1 = 0;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].we) begin
        wb_write(tbl[i].dat);
        if (i == 0) e1 = wr_edge;
        r = rdt;
      end else begin
        wb_read(r);
      end
      check("t3_table", r, tbl[i].exp_rdt);
    end
    idle(210);
    check_frame("t3_f0", 8'h11, e1 + 1);
    check_frame("t3_f1", 8'h22, e1 + 1 + FRAME);
    check_frame("t3_f2", 8'h33, e1 + 1 + 2*FRAME);
    check_frame("t3_f3", 8'h44, e1 + 1 + 3*FRAME);
    check_frame("t3_f4", 8'h55, e1 + 1 + 4*FRAME);
    check("t3_dropped", {31'b0, tx_log[e1 + 1 + 5*FRAME]}, 32'd1);

    // 4: two contiguous frames
    wb_write(8'hA5);
    e = wr_edge;
    wb_write(8'h3C);
    idle(90);
    check_frame("t4_f0", 8'hA5, e + 1);
    check_frame("t4_f1", 8'h3C, e + 1 + FRAME);
    check("t4_end", {31'b0, tx_log[e + 1 + 2*FRAME]}, 32'd1);

    // 5: reset during a data bit with two bytes queued
    wb_write(8'h81);
    e = wr_edge;
    wb_write(8'h42);
    wb_write(8'h99);
    while (cyc_n < e + 7) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    rst_edge = cyc_n;
    check("t5_tx_after_rst", {31'b0, tx}, 32'd1);
    wb_read(r);
    check("t5_status", r, 32'h0000_0004);
    idle(100);
    zeros = 0;
    for (int k = rst_edge; k < tx_log.size(); k++) if (tx_log[k] == 1'b0) zeros++;
    check("t5_quiet", zeros, 32'd0);

    // 6: push lands on the stop-to-start edge with one byte queued
    wb_write(8'hC3);
    e = wr_edge;
    wb_write(8'h5A);
    while (cyc_n < e + FRAME) cycle();
    wb_write(8'h0F);
    wb_read(r);
    check("t6_status", r, 32'h0000_0101);
    idle(100);
    check_frame("t6_f0", 8'hC3, e + 1);
    check_frame("t6_f1", 8'h5A, e + 1 + FRAME);
    check_frame("t6_f2", 8'h0F, e + 1 + 2*FRAME);
    check("t6_end", {31'b0, tx_log[e + 1 + 3*FRAME]}, 32'd1);

    // Random traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      int sel;
      sel = int'($urandom_range(0, 39));
      if (sel < 20) begin
        wb_write(8'($urandom));
      end else if (sel < 28) begin
        wb_read(r);
      end else if (sel < 39) begin
        idle(int'($urandom_range(1, 12 * DIV)));
      end else begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
    end
    idle(6 * FRAME);
    wb_read(r);
    check("final_status", r, 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
